// File: rtl/clk_gen81_if.sv
// rtl/clk_gen81_if.sv - divider control/write port and divided clock bus.
interface clk_gen81_if #(
  parameter int DIV_W = 8
);
  logic [7:0]       i_en;
  logic             i_wr;
  logic [2:0]       i_addr;
  logic [DIV_W-1:0] i_div;
  logic             i_sync;
  logic [7:0]       o_clk;
  logic [7:0]       o_pend;

  modport master (
    output i_en, i_wr, i_addr, i_div, i_sync,
    input  o_clk, o_pend
  );

  modport slave (
    input  i_en, i_wr, i_addr, i_div, i_sync,
    output o_clk, o_pend
  );
endinterface

// File: rtl/clk_gen81.sv
// rtl/clk_gen81.sv - eight-channel 50%-duty programmable clock divider.
// Optional phase-align on i_sync when CLK_GEN81_SYNC_EN is defined.
module clk_gen81 #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  clk_gen81_if.slave  bus
);
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q [8];
  state_t           state_d [8];
  logic [DIV_W-1:0] cnt_q   [8];
  logic [DIV_W-1:0] cnt_d   [8];
  logic [DIV_W-1:0] div_q   [8];
  logic [DIV_W-1:0] div_d   [8];
  logic [DIV_W-1:0] pdiv_q  [8];
  logic [DIV_W-1:0] pdiv_d  [8];
  logic [7:0]       clk_q, clk_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       stop_q, stop_d;
  logic [7:0]       apply;

`ifndef CLK_GEN81_SYNC_EN
  logic unused_sync;
  assign unused_sync = bus.i_sync;
`endif

  always_comb begin
    clk_d  = clk_q;
    pend_d = pend_q;
    stop_d = stop_q;
    apply  = '0;
    for (int k = 0; k < 8; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      div_d[k]   = div_q[k];
      pdiv_d[k]  = pdiv_q[k];
      case (state_q[k])
        IDLE: begin
          cnt_d[k]  = '0;
          clk_d[k]  = 1'b0;
          stop_d[k] = 1'b0;
          apply[k]  = 1'b1;
          if (bus.i_en[k]) state_d[k] = RUN;
        end
        default: begin
          if (!bus.i_en[k]) stop_d[k] = 1'b1;
          if (cnt_q[k] == div_q[k]) begin
            cnt_d[k] = '0;
            clk_d[k] = ~clk_q[k];
            // High-to-low toggle closes a full period: safe point to stop or retune.
            if (clk_q[k]) begin
              apply[k] = 1'b1;
              if (stop_q[k] || !bus.i_en[k]) begin
                state_d[k] = IDLE;
                stop_d[k]  = 1'b0;
              end
            end
          end else begin
            cnt_d[k] = cnt_q[k] + DIV_W'(1);
          end
        end
      endcase
`ifdef CLK_GEN81_SYNC_EN
      if (bus.i_sync) begin
        apply[k] = 1'b1;
        if (state_q[k] == RUN) begin
          cnt_d[k] = '0;
          clk_d[k] = 1'b0;
        end
      end
`endif
      if (apply[k]) begin
        div_d[k]  = pdiv_q[k];
        pend_d[k] = 1'b0;
      end
      // A write in the apply cycle is held for the next boundary.
      if (bus.i_wr && bus.i_addr == 3'(k)) begin
        pdiv_d[k] = bus.i_div;
        pend_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_q  <= '0;
      pend_q <= '0;
      stop_q <= '0;
      for (int k = 0; k < 8; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
        div_q[k]   <= DEF;
        pdiv_q[k]  <= DEF;
      end
    end else begin
      clk_q  <= clk_d;
      pend_q <= pend_d;
      stop_q <= stop_d;
      for (int k = 0; k < 8; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        div_q[k]   <= div_d[k];
        pdiv_q[k]  <= pdiv_d[k];
      end
    end
  end

  assign bus.o_clk  = clk_q;
  assign bus.o_pend = pend_q;
endmodule

// File: tb/tb_clk_gen81.sv
// tb/tb_clk_gen81.sv - self-checking bench for clk_gen81 (vector table plus scoreboard).
module tb_clk_gen81;
  logic clk;
  logic rst_n;

  clk_gen81_if #(.DIV_W(8)) bus ();

  clk_gen81 #(.DIV_W(8), .DEF_DIV(0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] clk;
    logic [7:0] pend;
    logic [7:0] mask;
    string      name;
  } exp_t;

  typedef struct {
    logic [7:0] en;
    logic       sync;
    logic [7:0] clk;
    logic [7:0] pend;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

`ifdef CLK_GEN81_SYNC_EN
  localparam logic SY_IGN = 1'b0;
`else
  localparam logic SY_IGN = 1'b1;
`endif

  task automatic cyc(input logic [7:0] en, input logic wr, input logic [2:0] addr,
                     input logic [7:0] dv, input logic sy, input logic [7:0] eclk,
                     input logic [7:0] epend, input string nm);
    exp_t e;
    bus.i_en   = en;
    bus.i_wr   = wr;
    bus.i_addr = addr;
    bus.i_div  = dv;
    bus.i_sync = sy;
    sb.push_back('{eclk, epend, 8'hff, nm});
    @(posedge clk);
    #1;
    bus.i_wr   = 1'b0;
    bus.i_sync = 1'b0;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      if ((bus.o_clk & e.mask) !== (e.clk & e.mask)) begin
        bad++;
        $display("FAIL %s clk: got %h want %h", e.name, bus.o_clk, e.clk);
      end
      total++;
      if (bus.o_pend !== e.pend) begin
        bad++;
        $display("FAIL %s pend: got %h want %h", e.name, bus.o_pend, e.pend);
      end
    end
  endtask

  task automatic do_reset(input string nm);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.o_clk !== 8'h00 || bus.o_pend !== 8'h00) begin
      bad++;
      $display("FAIL %s: clk=%h pend=%h want 00/00", nm, bus.o_clk, bus.o_pend);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tv[9];
  logic [7:0] ec;
  logic [7:0] ep;

  initial begin
    rst_n      = 1'b0;
    bus.i_en   = '0;
    bus.i_wr   = 1'b0;
    bus.i_addr = '0;
    bus.i_div  = '0;
    bus.i_sync = 1'b0;

    tv[0] = '{8'h01, 1'b0,   8'h00, 8'h00};
    tv[1] = '{8'h01, 1'b0,   8'h01, 8'h00};
    tv[2] = '{8'h01, 1'b0,   8'h00, 8'h00};
    tv[3] = '{8'h01, SY_IGN, 8'h01, 8'h00};
    tv[4] = '{8'h01, 1'b0,   8'h00, 8'h00};
    tv[5] = '{8'h00, 1'b0,   8'h01, 8'h00};
    tv[6] = '{8'h00, 1'b0,   8'h00, 8'h00};
    tv[7] = '{8'h00, 1'b0,   8'h00, 8'h00};
    tv[8] = '{8'h00, 1'b0,   8'h00, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.o_clk !== 8'h00 || bus.o_pend !== 8'h00) begin
      bad++;
      $display("FAIL reset: clk=%h pend=%h want 00/00", bus.o_clk, bus.o_pend);
    end
    rst_n = 1'b1;

    // ch0 at DEF_DIV=0: i_clk/2, then stop after a full high phase
    for (int i = 0; i < 9; i++)
      cyc(tv[i].en, 1'b0, 3'd0, 8'd0, tv[i].sync, tv[i].clk, tv[i].pend, "ch0_div0");

    // ch3: idle write N=4, run, retune to N=1 mid-high
    do_reset("rst_ch3");
    cyc(8'h00, 1'b1, 3'd3, 8'd4, 1'b0, 8'h00, 8'h08, "ch3_wr_idle");
    cyc(8'h08, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 8'h00, "ch3_apply_idle");
    for (int s = 1; s <= 17; s++) begin
      ec = ((s >= 5 && s <= 9) || s == 12 || s == 13 || s == 16 || s == 17) ? 8'h08 : 8'h00;
      ep = (s >= 6 && s <= 9) ? 8'h08 : 8'h00;
      cyc(8'h08, s == 6, 3'd3, 8'd1, 1'b0, ec, ep, "ch3_run");
    end

    // ch5: write on falling toggle then overwrite; only N=6 takes effect
    do_reset("rst_ch5");
    cyc(8'h20, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 8'h00, "ch5_entry");
    for (int s = 1; s <= 17; s++) begin
      ec = (s == 1 || s == 3 || (s >= 11 && s <= 17)) ? 8'h20 : 8'h00;
      ep = (s == 2 || s == 3) ? 8'h20 : 8'h00;
      cyc(8'h20, s == 2 || s == 3, 3'd5, (s == 2) ? 8'd2 : 8'd6, 1'b0, ec, ep, "ch5_run");
    end
    do_reset("rst_midhigh");
    cyc(8'h20, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 8'h00, "ch5_def_entry");
    cyc(8'h20, 1'b0, 3'd0, 8'd0, 1'b0, 8'h20, 8'h00, "ch5_def_rise");
    cyc(8'h20, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 8'h00, "ch5_def_fall");

    // ch2 N=3: drop enable on first high cycle, high phase completes
    do_reset("rst_ch2");
    cyc(8'h00, 1'b1, 3'd2, 8'd3, 1'b0, 8'h00, 8'h04, "ch2_wr");
    cyc(8'h04, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 8'h00, "ch2_entry");
    for (int s = 1; s <= 15; s++) begin
      ec = (s >= 4 && s <= 7) ? 8'h04 : 8'h00;
      cyc((s < 5) ? 8'h04 : 8'h00, 1'b0, 3'd0, 8'd0, 1'b0, ec, 8'h00, "ch2_stop");
    end

`ifdef CLK_GEN81_SYNC_EN
    do_reset("rst_sync");
    cyc(8'h00, 1'b1, 3'd1, 8'd2, 1'b0, 8'h00, 8'h02, "sync_wr");
    cyc(8'h03, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 8'h00, "sync_entry");
    cyc(8'h03, 1'b0, 3'd0, 8'd0, 1'b0, 8'h01, 8'h00, "sync_s1");
    cyc(8'h03, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 8'h00, "sync_s2");
    cyc(8'h03, 1'b0, 3'd0, 8'd0, 1'b0, 8'h03, 8'h00, "sync_s3");
    cyc(8'h03, 1'b1, 3'd1, 8'd2, 1'b0, 8'h02, 8'h02, "sync_s4");
    cyc(8'h03, 1'b0, 3'd0, 8'd0, 1'b1, 8'h00, 8'h00, "sync_pulse");
    cyc(8'h03, 1'b0, 3'd0, 8'd0, 1'b0, 8'h01, 8'h00, "sync_s6");
    cyc(8'h03, 1'b0, 3'd0, 8'd0, 1'b0, 8'h00, 8'h00, "sync_s7");
    cyc(8'h03, 1'b0, 3'd0, 8'd0, 1'b0, 8'h03, 8'h00, "sync_s8");
    do_reset("rst_sync_run");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
